ped_request_conditioner: RTL and testbench

Upstream stage of `traffic_light_controller`. It turns four raw crosswalk push-buttons into the clean, sticky `pedestrian[3:0]` request vector that the controller consumes. Each button is synchronised, debounced and edge-detected, and its request is held until the controller's `pedestrian_grant` handshake serves it. It also keeps a saturating served-request count and, optionally, an over-wait `urgent` flag.

---
 rtl/ped_request_conditioner_pkg.sv | 22 ++
 rtl/ped_request_conditioner_if.sv | 47 ++++
 rtl/ped_request_conditioner_debounce.sv | 52 +++++
 rtl/ped_request_conditioner.sv | 108 ++++++++++
 tb/tb_ped_request_conditioner.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ped_request_conditioner_pkg.sv
// Shared types and constants for the pedestrian request conditioner.
// Provides the grant FSM encoding and a saturating adder for the served-request count.
package ped_pkg;

    localparam int NUM_CH_DEFAULT = 4;
    localparam int REQ_COUNT_W    = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        SERVING = 1'b1
    } ped_grant_state_t;

    function automatic logic [REQ_COUNT_W-1:0] sat_add(
        input logic [REQ_COUNT_W-1:0] a,
        input logic [REQ_COUNT_W-1:0] b
    );
        logic [REQ_COUNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[REQ_COUNT_W] ? '1 : sum[REQ_COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/ped_request_conditioner_if.sv
// Button/grant inputs and request outputs of the conditioner, grouped as one bundle.
// The urgent flag exists only when PED_URGENT_EN is defined.
interface ped_request_conditioner_if
    import ped_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) ();

    logic [NUM_CH-1:0]      btn;
    logic                   pedestrian_grant;
    logic [NUM_CH-1:0]      pedestrian;
    logic [REQ_COUNT_W-1:0] req_count;
`ifdef PED_URGENT_EN
    logic                   urgent;

    modport master (
        input  btn,
        input  pedestrian_grant,
        output pedestrian,
        output req_count,
        output urgent
    );

    modport slave (
        output btn,
        output pedestrian_grant,
        input  pedestrian,
        input  req_count,
        input  urgent
    );
`else
    modport master (
        input  btn,
        input  pedestrian_grant,
        output pedestrian,
        output req_count
    );

    modport slave (
        output btn,
        output pedestrian_grant,
        input  pedestrian,
        input  req_count
    );
`endif

endinterface

// File: rtl/ped_request_conditioner_debounce.sv
// One crosswalk channel: two-flop synchroniser, debounce filter and rising-edge press pulse.
module ped_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_flip;

    assign w_differs = r_sync2 ^ r_level;
    // The sample that would bring the count to DEBOUNCE_CYCLES flips the level instead.
    assign w_flip    = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_press <= w_flip & ~r_level;
            if (w_flip) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/ped_request_conditioner.sv
// Sticky pedestrian request vector with grant handshake and saturating served count.
// Define PED_URGENT_EN to add the over-wait counter and the urgent output.
module ped_request_conditioner
    import ped_pkg::*;
#(
    parameter int NUM_CH          = NUM_CH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_WAIT        = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    ped_request_conditioner_if.master bus
);

    if (DEBOUNCE_CYCLES < 1 || MAX_WAIT < 1) begin : g_bad_cfg
        $error("ped_request_conditioner: DEBOUNCE_CYCLES and MAX_WAIT must be at least 1");
    end

    logic [NUM_CH-1:0]      w_press;
    logic [NUM_CH-1:0]      w_level;
    logic [NUM_CH-1:0]      w_new_req;
    logic [REQ_COUNT_W-1:0] w_served;
    logic                   w_grant_edge;

    logic [NUM_CH-1:0]      r_pending;
    logic [REQ_COUNT_W-1:0] r_req_count;
    logic                   r_grant_d;
    ped_grant_state_t       r_state;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ped_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (bus.btn[gi]),
            .o_level(w_level[gi]),
            .o_press(w_press[gi])
        );
    end

    assign w_new_req    = w_press & w_level;
    assign w_grant_edge = bus.pedestrian_grant & ~r_grant_d & (r_state == IDLE);

    always_comb begin
        w_served = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_served = w_served + REQ_COUNT_W'(r_pending[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant_d   <= 1'b0;
            r_pending   <= '0;
            r_req_count <= '0;
        end else begin
            r_grant_d <= bus.pedestrian_grant;
            case (r_state)
                IDLE:    if (w_grant_edge) r_state <= SERVING;
                SERVING: if (!bus.pedestrian_grant) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // On the grant edge every pending bit is served; a press landing now re-arms its bit.
            if (w_grant_edge) begin
                r_pending   <= w_new_req;
                r_req_count <= sat_add(r_req_count, w_served);
            end else begin
                r_pending   <= r_pending | w_new_req;
            end
        end
    end

    assign bus.pedestrian = r_pending;
    assign bus.req_count  = r_req_count;

`ifdef PED_URGENT_EN
    localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_urgent;

    always_comb begin
        w_wait_next = r_wait;
        if (w_grant_edge || (r_pending == '0)) begin
            w_wait_next = '0;
        end else if ((r_state == IDLE) && (r_wait != WAIT_MAX)) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait   <= '0;
            r_urgent <= 1'b0;
        end else begin
            r_wait   <= w_wait_next;
            r_urgent <= (w_wait_next == WAIT_MAX);
        end
    end

    assign bus.urgent = r_urgent;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench: directed scenarios then random buttons/grant/reset against a window-based model.
module tb_ped_request_conditioner;
    import ped_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int MW = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ped_request_conditioner_if #(.NUM_CH(N)) bus ();

    ped_request_conditioner #(
        .NUM_CH         (N),
        .DEBOUNCE_CYCLES(D),
        .MAX_WAIT       (MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: q[0] is the newest raw sample, q[k] the one k edges older.
    logic [N-1:0] q [0:D];
    logic [N-1:0] m_lvl   = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_pend  = '0;
    int           m_cnt   = 0;
    logic         m_gd    = 1'b0;
`ifdef PED_URGENT_EN
    int           m_wait  = 0;
    logic         m_urg   = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] flip;
        logic         gedge;
        if (!rst) begin
            for (int k = 0; k <= D; k++) q[k] = '0;
            m_lvl = '0; m_press = '0; m_pend = '0; m_cnt = 0; m_gd = 1'b0;
`ifdef PED_URGENT_EN
            m_wait = 0; m_urg = 1'b0;
`endif
        end else begin
            gedge = bus.pedestrian_grant && !m_gd;
`ifdef PED_URGENT_EN
            if (gedge || m_pend == '0) m_wait = 0;
            else if (!m_gd && m_wait < MW) m_wait++;
            m_urg = (m_wait == MW);
`endif
            if (gedge) begin
                m_cnt  = (m_cnt + $countones(m_pend) > 255) ? 255 : m_cnt + $countones(m_pend);
                m_pend = m_press;
            end else begin
                m_pend = m_pend | m_press;
            end
            // Level flips once the D synchronised samples (two edges late) all disagree with it.
            for (int i = 0; i < N; i++) begin
                flip[i] = 1'b1;
                for (int k = 1; k <= D; k++) if (q[k][i] == m_lvl[i]) flip[i] = 1'b0;
            end
            m_press = flip & ~m_lvl;
            m_lvl   = m_lvl ^ flip;
            for (int k = D; k >= 1; k--) q[k] = q[k-1];
            q[0] = bus.btn;
            m_gd = bus.pedestrian_grant;
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("pedestrian", 32'(bus.pedestrian), 32'(m_pend));
            chk("req_count", 32'(bus.req_count), 32'(m_cnt));
`ifdef PED_URGENT_EN
            chk("urgent", 32'(bus.urgent), 32'(m_urg));
`endif
        end
    endtask

    initial begin
        for (int k = 0; k <= D; k++) q[k] = '0;
        bus.btn = '0;
        bus.pedestrian_grant = 1'b0;

        // Reset then idle
        rst = 1'b0; step(3); rst = 1'b1; step(1);
        chk("rst_ped", 32'(bus.pedestrian), 32'h0);
        chk("rst_cnt", 32'(bus.req_count), 32'h0);
`ifdef PED_URGENT_EN
        chk("rst_urg", 32'(bus.urgent), 32'h0);
`endif
        $display("phase reset: ped=%b cnt=%0d", bus.pedestrian, bus.req_count);

        // Clean press: visible exactly 7 edges after assertion, sticky after release
        bus.btn = 4'b0001; step(6);
        chk("press_early", 32'(bus.pedestrian), 32'h0);
        step(1);
        chk("press_lat", 32'(bus.pedestrian), 32'h1);
        step(3); bus.btn = '0; step(10);
        chk("release_hold", 32'(bus.pedestrian), 32'h1);
        $display("phase clean press: ped=%b", bus.pedestrian);

        // Glitch of 3 cycles on btn[2]
        bus.btn = 4'b0100; step(3); bus.btn = '0; step(10);
        chk("glitch", 32'(bus.pedestrian), 32'h1);
        $display("phase glitch: ped=%b", bus.pedestrian);

        // Build 0101 then serve it; press btn[1] during the grant
        bus.btn = 4'b0100; step(7);
        chk("pend_0101", 32'(bus.pedestrian), 32'h5);
        bus.btn = '0; step(8);
        bus.pedestrian_grant = 1'b1; bus.btn = 4'b0010; step(1);
        chk("grant_clear", 32'(bus.pedestrian), 32'h0);
        chk("grant_cnt", 32'(bus.req_count), 32'd2);
        step(4); bus.pedestrian_grant = 1'b0; step(2);
        chk("press_in_grant", 32'(bus.pedestrian), 32'h2);
        step(3); bus.btn = '0; step(8);
        chk("after_grant", 32'(bus.pedestrian), 32'h2);
        $display("phase grant: ped=%b cnt=%0d", bus.pedestrian, bus.req_count);

        // Collision: new btn[0] press lands on the grant-edge cycle with pending[0] set
        bus.btn = 4'b0001; step(7); bus.btn = '0; step(8);
        bus.btn = 4'b0001; step(6);
        bus.pedestrian_grant = 1'b1; step(1);
        chk("collide_ped", 32'(bus.pedestrian), 32'h1);
        chk("collide_cnt", 32'(bus.req_count), 32'd4);
        bus.pedestrian_grant = 1'b0; step(2); bus.btn = '0; step(8);
        $display("phase collision: ped=%b cnt=%0d", bus.pedestrian, bus.req_count);

        // Over-wait: pending 1000 with no grant
        bus.pedestrian_grant = 1'b1; step(1); bus.pedestrian_grant = 1'b0; step(2);
        bus.btn = 4'b1000; step(7);
        chk("pend_1000", 32'(bus.pedestrian), 32'h8);
`ifdef PED_URGENT_EN
        step(19);
        chk("urg_early", 32'(bus.urgent), 32'h0);
        step(1);
        chk("urg_set", 32'(bus.urgent), 32'h1);
        bus.pedestrian_grant = 1'b1; step(1);
        chk("urg_clear", 32'(bus.urgent), 32'h0);
`else
        step(20);
        bus.pedestrian_grant = 1'b1; step(1);
`endif
        chk("urg_phase_cnt", 32'(bus.req_count), 32'd6);
        bus.pedestrian_grant = 1'b0; bus.btn = '0; step(8);
        $display("phase urgent: ped=%b cnt=%0d", bus.pedestrian, bus.req_count);

        // Reset mid-operation with buttons held
        bus.btn = 4'b0011; step(7);
        chk("pend_0011", 32'(bus.pedestrian), 32'h3);
        rst = 1'b0; step(2);
        chk("midrst_ped", 32'(bus.pedestrian), 32'h0);
        chk("midrst_cnt", 32'(bus.req_count), 32'h0);
        rst = 1'b1; step(6);
        chk("rst_repress_early", 32'(bus.pedestrian), 32'h0);
        step(1);
        chk("rst_repress", 32'(bus.pedestrian), 32'h3);
        step(20);
        chk("held_once", 32'(bus.pedestrian), 32'h3);
        bus.pedestrian_grant = 1'b1; step(1);
        chk("held_cnt", 32'(bus.req_count), 32'd2);
        bus.pedestrian_grant = 1'b0; bus.btn = '0; step(8);
        $display("phase mid reset: ped=%b cnt=%0d", bus.pedestrian, bus.req_count);

        // Random buttons, grant pulses and occasional reset
        for (int c = 0; c < 8000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) bus.btn[i] = ~bus.btn[i];
            end
            if ($urandom_range(0, 7) == 0) bus.pedestrian_grant = ~bus.pedestrian_grant;
            rst = (c >= 5000 && $urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        $display("phase random: ped=%b cnt=%0d", bus.pedestrian, bus.req_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
